seg_dynamic_param: RTL
======================

Name: seg_dynamic_param

Overview:
Parametrised N-digit multiplexed 7-segment driver; successor to the fixed 6-digit, 20-bit display driver.
Converts unsigned binary `data` to BCD with a sequential double-dabble engine, then scans the digits. Adds leading-zero blanking, a sign digit, a per-digit decimal point, per-digit blink and overflow indication.
Sits between application logic (counters, measurements) and the board's digit-select and segment pins (or the 74HC595 serialiser stage).

Parameters:
DIGITS, 6, number of physical digits (2..8); sel width.
DATA_W, 20, binary input width (4..27).
CNT_MAX, 16'd49_999, scan divider; each digit is lit for CNT_MAX+1 clocks (1 ms at 50 MHz). Benches override it to 5.
BLINK_MAX, 25'd24_999_999, blink half-period minus one, in clocks.

Ports:
sys_clk  input  1  system clock, rising edge
sys_rst_n  input  1  reset, synchronous, active-low
data  input  DATA_W  unsigned magnitude to display
point  input  DIGITS  decimal-point enable per digit; bit0 = rightmost
sign  input  1  1 = show minus before the most significant shown digit
blink  input  DIGITS  per-digit blink enable
seg_en  input  1  display enable
sel  output  DIGITS  one-hot digit select, active-high; bit0 = rightmost
seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - sel=0, seg=8'hFF, all counters and FSM cleared, display registers blank.
  - Applies from the next edge, also mid-scan or mid-conversion.
- Converter FSM, free-running: LOAD -> SHIFT -> LATCH -> LOAD.
  - LOAD (1 clk): snapshot data, sign, point; clear the BCD register.
  - SHIFT (DATA_W clks): add 3 to every BCD nibble >= 5, then shift left one bit.
  - LATCH (1 clk): compute display codes and write them to the display registers atomically.
  - Period is DATA_W+2 clocks. The scan side never sees partial BCD.
  - Input change reaches the display registers within 2*(DATA_W+2) clocks.
- BCD width: BCD_D = (DATA_W*3)/10+1 nibbles.
- Display code rules, applied in LATCH:
  - msd = index of the highest nonzero BCD nibble (0 if the value is 0).
  - top = max(msd, index of highest set point bit).
  - Digits above top are blank (8'hFF). Digit 0 is always shown.
  - If sign=1, digit top+1 shows minus (8'hBF).
  - Overflow if any nibble >= DIGITS is nonzero, or sign=1 and top = DIGITS-1. On overflow every digit shows 8'hBF and dp is off.
  - dp: a shown digit with point[i]=1 has seg[7] cleared. Blank and minus digits ignore point.
- Segment codes for 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
- Scan:
  - cnt counts 0..CNT_MAX and wraps.
  - On wrap, idx advances 0..DIGITS-1 and wraps to 0.
  - sel and seg are registered together in the same cycle: sel = 1<<idx, seg = code[idx].
- Blink:
  - blink_cnt counts 0..BLINK_MAX; phase toggles on each wrap. Phase=0 after reset.
  - While phase=1, a digit with blink[i]=1 outputs 8'hFF. sel is unaffected.
  - blink is sampled live, not snapshotted.
- seg_en:
  - seg_en=0: sel=0 and seg=8'hFF on the next edge. Scan and converter keep running.
  - Re-enable: output resumes at the current idx on the next edge.

Decomposition:
- Shared package seg_pkg:
  - segment code constants SEG_DIGIT[0:9], SEG_BLANK=8'hFF, SEG_MINUS=8'hBF
  - converter state typedef {LOAD, SHIFT, LATCH}
  - function bcd_digits(DATA_W)
- One sub-module: bin2bcd_seq.
  - Parameters DATA_W, BCD_D.
  - Sequential double-dabble with start/done pulse.
- Top holds scan, blink, blanking and encoding.

Test Plan:
1. Defaults with CNT_MAX=5, data=9876, point=6'b000010, sign=1, seg_en=1. Expect the scan to show "-98.76":
   - d0=82, d1=78, d2=80, d3=90, d4=BF, d5=FF
   - each sel held 6 clks, cyclic order 1,2,4,8,16,32.
2. data=5, point=6'b000100, sign=0 -> "0.05": d0=92, d1=C0, d2=40, d3..d5=FF. data=0, point=0 -> d0=C0, rest FF.
3. Overflow cases:
   - data=1_000_000 -> all six digits BF.
   - data=123456 with sign=1 -> all BF.
   - data=999999 with sign=0 -> 90 on every digit.
4. Update latency: data switches 1234 -> 4321 mid-conversion.
   - Display registers change exactly once, to 4321, within 44 clks.
   - No intermediate code ever appears on seg.
5. Enable and reset:
   - seg_en 1->0 mid-digit -> next edge sel=0, seg=FF; re-enable resumes at the same idx.
   - sys_rst_n low for 1 clk mid-scan -> sel=0, seg=FF at that edge; scan restarts at digit 0.
6. Blink with BLINK_MAX=9, blink=6'b000001, data=7:
   - d0 alternates F8 / FF every 10 clks.
   - Other digits and sel are unaffected.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver:
// segment codes, converter state type and BCD sizing helper.
package seg_pkg;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a} for digits 0..9.
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Converter sequence: snapshot, DATA_W shift steps, publish.
  typedef enum logic [1:0] {
    CONV_LOAD  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_LATCH = 2'd2
  } conv_state_t;

  // Number of BCD nibbles needed to hold any DATA_W-bit unsigned value.
  function automatic int bcd_digits(input int data_w);
    return (data_w * 3) / 10 + 1;
  endfunction

  // Segment pattern for one BCD nibble; non-decimal nibbles render blank.
  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    if (nib <= 4'd9) return SEG_DIGIT[nib];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
// start/done: start is sampled in LOAD; while high the converter snapshots
// bin and begins a conversion. done is high for exactly the one LATCH cycle,
// during which bcd holds the complete result; bcd is never valid otherwise.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int BCD_D  = bcd_digits(20)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_W-1:0]    bin,
  output logic [4*BCD_D-1:0]   bcd,
  output logic                 done,
  output conv_state_t          state
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0]  bin_q;
  logic [CNT_W-1:0]   step;
  logic [4*BCD_D-1:0] bcd_adj;

  // Add-3 correction for every nibble that would overflow on the next shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_D; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM with snapshot, shift engine and step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CONV_LOAD;
      bin_q <= '0;
      bcd   <= '0;
      step  <= '0;
    end else begin
      case (state)
        CONV_LOAD: begin
          if (start) begin
            bin_q <= bin;
            bcd   <= '0;
            step  <= '0;
            state <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          bcd   <= {bcd_adj[4*BCD_D-2:0], bin_q[DATA_W-1]};
          bin_q <= bin_q << 1;
          step  <= step + 1'b1;
          if (step == LAST_STEP) state <= CONV_LATCH;
        end
        default: state <= CONV_LOAD;
      endcase
    end
  end

  assign done = (state == CONV_LATCH);

endmodule

// File: rtl/seg_dynamic_param.sv
// Parametrised N-digit multiplexed 7-segment driver: converts binary data to
// BCD, builds per-digit codes (blanking, sign, decimal point, overflow) and
// scans them onto one-hot digit selects with optional per-digit blink.
module seg_dynamic_param
  import seg_pkg::*;
#(
  parameter int          DIGITS    = 6,
  parameter int          DATA_W    = 20,
  parameter logic [15:0] CNT_MAX   = 16'd49_999,
  parameter logic [24:0] BLINK_MAX = 25'd24_999_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic [DIGITS-1:0] point,
  input  logic              sign,
  input  logic [DIGITS-1:0] blink,
  input  logic              seg_en,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg
);

  localparam int BCD_D = bcd_digits(DATA_W);
  localparam int NIB_N = (BCD_D > DIGITS) ? BCD_D : DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [4*BCD_D-1:0] bcd;
  logic [4*NIB_N-1:0] bcd_ext;
  logic               conv_done;
  conv_state_t        conv_state;

  logic [DIGITS-1:0]  point_q;
  logic               sign_q;
  logic [7:0]         code_next [DIGITS];
  logic [7:0]         code_q    [DIGITS];

  logic [15:0]        cnt;
  logic [IDX_W-1:0]   idx;
  logic [24:0]        blink_cnt;
  logic               blink_phase;

  int msd;
  int pt_top;
  int top;
  logic ovf;

  bin2bcd_seq #(.DATA_W(DATA_W), .BCD_D(BCD_D)) u_bin2bcd (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .start (1'b1),
    .bin   (data),
    .bcd   (bcd),
    .done  (conv_done),
    .state (conv_state)
  );

  assign bcd_ext = (4*NIB_N)'(bcd);

  // Snapshot sign and decimal points alongside the converter's data snapshot.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      point_q <= '0;
      sign_q  <= 1'b0;
    end else if (conv_state == CONV_LOAD) begin
      point_q <= point;
      sign_q  <= sign;
    end
  end

  // Display code generation from the finished BCD value.
  always_comb begin
    msd    = 0;
    pt_top = 0;
    ovf    = 1'b0;
    for (int i = 0; i < NIB_N; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) begin
        msd = i;
        if (i >= DIGITS) ovf = 1'b1;
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (point_q[i]) pt_top = i;
    end
    top = (msd > pt_top) ? msd : pt_top;
    if (sign_q && (top == DIGITS - 1)) ovf = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf) begin
        code_next[i] = SEG_MINUS;
      end else if (i <= top) begin
        code_next[i] = seg_code(bcd_ext[4*i +: 4]) & (point_q[i] ? 8'h7F : 8'hFF);
      end else if (sign_q && (i == top + 1)) begin
        code_next[i] = SEG_MINUS;
      end else begin
        code_next[i] = SEG_BLANK;
      end
    end
  end

  // Display registers update atomically once per finished conversion.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DIGITS; i++) code_q[i] <= SEG_BLANK;
    end else if (conv_done) begin
      for (int i = 0; i < DIGITS; i++) code_q[i] <= code_next[i];
    end
  end

  // Scan divider and digit index.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Blink half-period counter and phase.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Registered digit select and segment outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || !seg_en) begin
      sel <= '0;
      seg <= SEG_BLANK;
    end else begin
      sel <= DIGITS'(1) << idx;
      seg <= (blink_phase && blink[idx]) ? SEG_BLANK : code_q[idx];
    end
  end

endmodule
